// File: rtl/gift_cofb_pkg.sv
// Shared types and constants for the GIFT-COFB round-key sequencer and the
// reusable key-update block.
package gift_cofb_pkg;

  typedef enum logic {StIdle, StRun} ks_state_e;

  localparam logic [31:0] KuMaskNib   = 32'h0000000f;
  localparam logic [31:0] KuMaskLo12  = 32'h00000fff;
  localparam logic [31:0] KuMaskHi14  = 32'h3fff0000;
  localparam logic [31:0] KuMaskBit17 = 32'h00030000;

  localparam int unsigned RoundsDefault = 40;

endpackage

// File: rtl/gift_cofb_keysched_seq_if.sv
// Key-load and round-key stream bundle for gift_cofb_keysched_seq.
// The abort signal exists only when GIFT_COFB_KS_ABORT_EN is defined.
interface gift_cofb_keysched_seq_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_data;
  logic         rk_valid;
  logic         rk_ready;
  logic [31:0]  rk_data;
  logic [6:0]   rk_idx;
  logic         rk_last;
  logic         busy;
`ifdef GIFT_COFB_KS_ABORT_EN
  logic         abort;

  modport master (
    output key_valid, key_data, rk_ready, abort,
    input  key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
  );
  modport slave (
    input  key_valid, key_data, rk_ready, abort,
    output key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
  );
`else
  modport master (
    output key_valid, key_data, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
  );
  modport slave (
    input  key_valid, key_data, rk_ready,
    output key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
  );
`endif
endinterface

// File: rtl/gift_cofb_key_update.sv
// GIFT-128 32-bit key-word update: low half rotated right by 12, high half
// rotated right by 2. Purely combinational.
module gift_cofb_key_update
  import gift_cofb_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = ((x >> 12) & KuMaskNib)  |
             ((x & KuMaskLo12) << 4)  |
             ((x >> 2) & KuMaskHi14)  |
             ((x & KuMaskBit17) << 14);

endmodule

// File: rtl/gift_cofb_keysched_seq.sv
// GIFT-128 round-key word sequencer: loads a 128-bit key, streams 2*ROUNDS words.
// Optional abort input enabled by defining GIFT_COFB_KS_ABORT_EN.
module gift_cofb_keysched_seq
  import gift_cofb_pkg::*;
#(
  parameter int unsigned ROUNDS = RoundsDefault
) (
  input logic                      clk,
  input logic                      rst,
  gift_cofb_keysched_seq_if.slave  bus
);

  localparam int unsigned NWORDS  = 2 * ROUNDS;
  localparam logic [6:0]  LastIdx = 7'(NWORDS - 1);

  ks_state_e   state;
  logic [31:0] win [4];
  logic [6:0]  idx;
  logic [31:0] rk_data_q;
  logic        rk_last_q;

  logic [31:0] ku_r0;
  logic [31:0] ku_r2;
  logic [1:0]  next_sel;
  logic [31:0] next_word;
  logic        hs;
  logic        abort_req;

  gift_cofb_key_update u_ku_r0 (.x(win[0]), .y(ku_r0));
  gift_cofb_key_update u_ku_r2 (.x(win[2]), .y(ku_r2));

  assign hs = (state == StRun) && bus.rk_ready;

`ifdef GIFT_COFB_KS_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Word following the current one; at a window wrap the new r0 is the old r1.
  always_comb begin
    next_sel  = idx[1:0] + 2'd1;
    next_word = win[next_sel];
    if (idx[1:0] == 2'd3) begin
      next_word = win[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      win       <= '{default: '0};
      idx       <= '0;
      rk_data_q <= '0;
      rk_last_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.key_valid) begin
            win[0]    <= bus.key_data[127:96];
            win[1]    <= bus.key_data[63:32];
            win[2]    <= bus.key_data[95:64];
            win[3]    <= bus.key_data[31:0];
            idx       <= '0;
            rk_data_q <= bus.key_data[127:96];
            rk_last_q <= 1'b0;
            state     <= StRun;
          end
        end
        StRun: begin
          if (abort_req || (hs && rk_last_q)) begin
            rk_last_q <= 1'b0;
            state     <= StIdle;
          end else if (hs) begin
            idx       <= idx + 7'd1;
            rk_data_q <= next_word;
            rk_last_q <= ((idx + 7'd1) == LastIdx);
            if (idx[1:0] == 2'd3) begin
              win[0] <= win[1];
              win[1] <= ku_r0;
              win[2] <= win[3];
              win[3] <= ku_r2;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.key_ready = (state == StIdle);
  assign bus.busy      = (state == StRun);
  assign bus.rk_valid  = (state == StRun);
  assign bus.rk_data   = rk_data_q;
  assign bus.rk_idx    = idx;
  assign bus.rk_last   = rk_last_q;

endmodule

// File: tb/tb_gift_cofb_keysched_seq.sv
// Directed self-checking bench for gift_cofb_keysched_seq.
module tb_gift_cofb_keysched_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gift_cofb_keysched_seq_if bus ();

  gift_cofb_keysched_seq dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] w [80];

  localparam logic [127:0] KeyA = {32'h00000001, 32'h00010000, 32'h00001000, 32'h00000000};
  localparam logic [127:0] KeyB = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hcafef00d};
  localparam logic [127:0] KeyC = {32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0};

  // Key update as two independent half-word rotations.
  function automatic logic [31:0] ku_ref(input logic [31:0] x);
    return {x[17:16], x[31:18], x[11:0], x[15:12]};
  endfunction

  task automatic build_model(input logic [127:0] k);
    w[0] = k[127:96];
    w[1] = k[63:32];
    w[2] = k[95:64];
    w[3] = k[31:0];
    for (int i = 0; i + 4 < 80; i += 4) begin
      w[i+4] = w[i+1];
      w[i+5] = ku_ref(w[i]);
      w[i+6] = w[i+3];
      w[i+7] = ku_ref(w[i+2]);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_data  = k;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    bus.rk_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.key_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", bus.key_ready); end
    if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", bus.rk_valid); end
    if (bus.rk_data !== 32'h0) begin errors++; $display("FAIL reset_rk_data got %h exp 0", bus.rk_data); end
    if (bus.rk_idx !== 7'd0) begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", bus.rk_idx); end
    if (bus.rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last got %b exp 0", bus.rk_last); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_vector();
    logic [31:0] exp_w [8];
    bit ok;
    exp_w = '{32'h00000001, 32'h00001000, 32'h00010000, 32'h00000000,
              32'h00001000, 32'h00000010, 32'h00000000, 32'h40000000};
    bus.rk_ready = 1'b1;
    send_key(KeyA);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.rk_valid !== 1'b1) begin errors++; $display("FAIL vec_valid[%0d] got %b exp 1", i, bus.rk_valid); end
      if (bus.rk_data !== exp_w[i]) begin errors++; $display("FAIL vec_data[%0d] got %h exp %h", i, bus.rk_data, exp_w[i]); end
      if (bus.rk_idx !== 7'(i)) begin errors++; $display("FAIL vec_idx[%0d] got %0d exp %0d", i, bus.rk_idx, i); end
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vec_drain got timeout exp key_ready"); end
  endtask

  task automatic test_zero_key();
    int cnt = 0;
    int cyc = 0;
    bit done = 1'b0;
    bus.rk_ready = 1'b1;
    send_key('0);
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (bus.rk_valid === 1'b1) begin
        checks += 3;
        if (bus.rk_data !== 32'h0) begin errors++; $display("FAIL zero_data[%0d] got %h exp 0", cnt, bus.rk_data); end
        if (bus.rk_idx !== 7'(cnt)) begin errors++; $display("FAIL zero_idx got %0d exp %0d", bus.rk_idx, cnt); end
        if (bus.rk_last !== (cnt == 79)) begin errors++; $display("FAIL zero_last[%0d] got %b exp %b", cnt, bus.rk_last, cnt == 79); end
        cnt++;
      end else begin
        checks++;
        if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL zero_key_ready got %b exp 1", bus.key_ready); end
        done = 1'b1;
        break;
      end
    end
    checks += 3;
    if (!done) begin errors++; $display("FAIL zero_end got timeout exp idle"); end
    if (cnt != 80) begin errors++; $display("FAIL zero_count got %0d exp 80", cnt); end
    if (cyc != 80) begin errors++; $display("FAIL zero_cycles got %0d exp 80", cyc); end
  endtask

  task automatic test_stall();
    int exp_i = 0;
    bit prev_stall = 1'b0;
    logic [31:0] p_data;
    logic [6:0]  p_idx;
    logic        p_last;
    build_model(KeyB);
    bus.rk_ready = 1'b0;
    send_key(KeyB);
    for (int c = 0; c < 400 && exp_i < 80; c++) begin
      @(negedge clk);
      checks += 4;
      if (bus.rk_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", exp_i, bus.rk_valid); end
      if (bus.rk_data !== w[exp_i]) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", exp_i, bus.rk_data, w[exp_i]); end
      if (bus.rk_idx !== 7'(exp_i)) begin errors++; $display("FAIL stall_idx got %0d exp %0d", bus.rk_idx, exp_i); end
      if (bus.rk_last !== (exp_i == 79)) begin errors++; $display("FAIL stall_last[%0d] got %b exp %b", exp_i, bus.rk_last, exp_i == 79); end
      if (prev_stall) begin
        checks++;
        if ({bus.rk_data, bus.rk_idx, bus.rk_last} !== {p_data, p_idx, p_last}) begin
          errors++; $display("FAIL stall_hold got %h/%0d/%b exp %h/%0d/%b",
                             bus.rk_data, bus.rk_idx, bus.rk_last, p_data, p_idx, p_last);
        end
      end
      p_data = bus.rk_data; p_idx = bus.rk_idx; p_last = bus.rk_last;
      bus.rk_ready = ((c % 5) == 1) || ((c % 5) == 3) || (c > 200);
      prev_stall = !bus.rk_ready;
      if (bus.rk_ready) exp_i++;
    end
    @(negedge clk);
    checks += 2;
    if (exp_i != 80) begin errors++; $display("FAIL stall_count got %0d exp 80", exp_i); end
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL stall_key_ready got %b exp 1", bus.key_ready); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.rk_ready = 1'b1;
    send_key(KeyB);
    @(negedge clk);
    for (int c = 0; c < 100 && bus.rk_idx !== 7'd37; c++) @(negedge clk);
    checks++;
    if (bus.rk_idx !== 7'd37) begin errors++; $display("FAIL rstmid_reach got %0d exp 37", bus.rk_idx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.rk_valid); end
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL rstmid_key_ready got %b exp 1", bus.key_ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
    build_model(KeyC);
    send_key(KeyC);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks += 2;
      if (bus.rk_idx !== 7'(i)) begin errors++; $display("FAIL rstmid_idx got %0d exp %0d", bus.rk_idx, i); end
      if (bus.rk_data !== w[i]) begin errors++; $display("FAIL rstmid_data[%0d] got %h exp %h", i, bus.rk_data, w[i]); end
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_drain got timeout exp key_ready"); end
  endtask

  task automatic test_key_ignored();
    build_model(KeyC);
    bus.rk_ready = 1'b1;
    send_key(KeyC);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      checks += 2;
      if (bus.rk_data !== w[i]) begin errors++; $display("FAIL ign_data[%0d] got %h exp %h", i, bus.rk_data, w[i]); end
      if (bus.rk_idx !== 7'(i)) begin errors++; $display("FAIL ign_idx got %0d exp %0d", bus.rk_idx, i); end
      if (i == 10) begin
        checks++;
        if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL ign_key_ready got %b exp 0", bus.key_ready); end
        bus.key_valid = 1'b1;
        bus.key_data  = KeyA;
      end
      if (i == 13) bus.key_valid = 1'b0;
    end
    @(negedge clk);
    checks += 2;
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL ign_end_ready got %b exp 1", bus.key_ready); end
    if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL ign_end_valid got %b exp 0", bus.rk_valid); end
  endtask

`ifdef GIFT_COFB_KS_ABORT_EN
  task automatic test_abort();
    bit ok;
    bus.rk_ready = 1'b1;
    send_key(KeyB);
    @(negedge clk);
    for (int c = 0; c < 50 && bus.rk_idx !== 7'd5; c++) @(negedge clk);
    checks++;
    if (bus.rk_idx !== 7'd5) begin errors++; $display("FAIL abort_reach got %0d exp 5", bus.rk_idx); end
    bus.abort = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.rk_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", bus.rk_valid); end
    if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL abort_key_ready got %b exp 1", bus.key_ready); end
    // abort stays high in IDLE alongside the new key
    build_model(KeyA);
    bus.key_valid = 1'b1;
    bus.key_data  = KeyA;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.abort     = 1'b0;
    checks += 3;
    if (bus.rk_valid !== 1'b1) begin errors++; $display("FAIL abort_reload_valid got %b exp 1", bus.rk_valid); end
    if (bus.rk_idx !== 7'd0) begin errors++; $display("FAIL abort_reload_idx got %0d exp 0", bus.rk_idx); end
    if (bus.rk_data !== w[0]) begin errors++; $display("FAIL abort_reload_data got %h exp %h", bus.rk_data, w[0]); end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_drain got timeout exp key_ready"); end
  endtask
`endif

  initial begin
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.rk_ready  = 1'b0;
`ifdef GIFT_COFB_KS_ABORT_EN
    bus.abort     = 1'b0;
`endif
    test_reset();
    test_vector();
    test_zero_key();
    test_stall();
    test_reset_mid();
    test_key_ignored();
`ifdef GIFT_COFB_KS_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gift_cofb_keysched_seq.md
# gift_cofb_keysched_seq

Round-key sequencer that sits directly upstream of the GIFT-COFB ISE's fixsliced key-update instructions and of the fixsliced round function. It accepts a 128-bit master key in one handshake and iteratively expands it into the classic GIFT-128 round-key word stream. The stream is `2*ROUNDS` 32-bit words, emitted one per cycle over a valid/ready interface. Downstream logic (ISE fixslice key-rearrange/update path or a round-key buffer) consumes the stream in index order.

## Interface
- `ROUNDS`, 40, number of cipher rounds; must be even; output stream length `NWORDS = 2*ROUNDS`.
- `clk` in 1, single clock; all state on rising edge.
- `rst` in 1, synchronous, active-high reset.
- `key_valid` in 1, master key present.
- `key_ready` out 1, block can accept a key; high only in IDLE.
- `key_data` in 128, master key; `key_data[32*j+31:32*j]` = key word `k[j]`, j=0..3.
- `rk_valid` out 1, `rk_data` holds a valid round-key word.
- `rk_ready` in 1, consumer accepts the word.
- `rk_data` out 32, round-key word `w[n]`.
- `rk_idx` out 7, index n of the current word, 0..NWORDS-1.
- `rk_last` out 1, high with `rk_valid` when `rk_idx == NWORDS-1`.
- `busy` out 1, high in RUN.
- `abort` in 1, present only with `GIFT_COFB_KS_ABORT_EN`.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `key_ready=1`.
  - On `key_valid && key_ready`, load window `r0=k[3], r1=k[1], r2=k[2], r3=k[0]`, set `idx=0`, and go to RUN.
- RUN:
  - `rk_data = r[idx mod 4]`, `rk_valid=1`.
  - Handshake (`rk_valid && rk_ready`) increments `idx`.
- Window advance on the handshake of a word with `idx mod 4 == 3`: `{r0,r1,r2,r3} <= {r1, ku(r0), r3, ku(r2)}`.
  - Equivalent recurrence for i multiple of 4: `w[i+4]=w[i+1]`, `w[i+5]=ku(w[i])`, `w[i+6]=w[i+3]`, `w[i+7]=ku(w[i+2])`.
- `ku(x)` is the 32-bit key update `((x>>12)&0x0000000f) | ((x&0x00000fff)<<4) | ((x>>2)&0x3fff0000) | ((x&0x00030000)<<14)`; purely combinational.
- Handshake on the word with `rk_last`: go to IDLE; the window is left as is (don't-care).
- `key_valid` is ignored in RUN; no queuing.
- `rk_ready` is ignored when `rk_valid=0`.
- `idx` is 7 bits and never wraps within a key; `NWORDS <= 128` is required.

## Timing
- Reset values: state=IDLE, `key_ready=1` (decoded from state), `rk_valid=0`, `rk_data=0`, `rk_idx=0`, `rk_last=0`, `busy=0`.
- `rst` dominates every other input in the same cycle; reset asserted mid-stream drops `rk_valid` the next cycle and returns to IDLE.
- Key handshake in cycle t gives `rk_valid=1` with `w[0]` in cycle t+1.
- Latency is one cycle per word: with `rk_ready` held high, the stream completes in NWORDS cycles.
- `key_ready` is high the cycle after the last word handshake.
- While `rk_valid && !rk_ready`: `rk_data`, `rk_idx` and `rk_last` are held stable.
- `rk_valid` never drops without a handshake, except on reset or abort.
- Outputs are registered or decoded from registers only; there is no combinational path from `rk_ready` or `key_valid` to any output.

## Configuration
- `GIFT_COFB_KS_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` high in RUN: the next cycle is IDLE with `rk_valid=0`, even if a handshake occurs in the same cycle. That handshake counts as consumed.
  - `abort` in IDLE has no effect; if `key_valid` coincides with it, the key is accepted.
- `GIFT_COFB_KS_ABORT_EN` undefined: no `abort` port; the stream always runs to completion or reset.

## Structure
- Shared package `gift_cofb_pkg` holds:
  - the state enum (IDLE, RUN);
  - key-update mask constants `0x0000000f`, `0x00000fff`, `0x3fff0000`, `0x00030000`;
  - the default round count.
- One sub-module, `gift_cofb_key_update`: 32-bit in, 32-bit out, combinational `ku`. It is instantiated twice (for r0 and r2) and is reusable by the ISE team.

## Test plan
- Key `k3=0x00000001, k2=0x00010000, k1=0x00001000, k0=0x00000000`, `rk_ready=1` → `w[0..7]` = 0x00000001, 0x00001000, 0x00010000, 0x00000000, 0x00001000, 0x00000010, 0x00000000, 0x40000000.
- All-zero key, `rk_ready=1` → 80 words of 0; `rk_last` only at `rk_idx=79`; `key_ready` high the following cycle; 80 valid cycles total.
- Random key with random `rk_ready` stalls → data, idx and last are stable while stalled; stream matches a C model of the recurrence for all 80 words.
- Reset asserted at `rk_idx=37` → next cycle `rk_valid=0`, `key_ready=1`; a new key restarts at `rk_idx=0`.
- `key_valid` pulsed during RUN with a different key → ignored; stream is unchanged.
- With `GIFT_COFB_KS_ABORT_EN`: abort at `rk_idx=5` together with a handshake → IDLE next cycle, no word 6 emitted; the next key is accepted the same cycle `key_valid` is raised.
